mem_loader: RTL

- Write-side counterpart of the project's asynchronous ROM read path.
- Accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into DATA_WIDTH-bit words.
- Drives a single synchronous write port (we/addr/wdata) on the program/data memory.
- Used to load images at boot or from a debug link, replacing $readmemh initialisation in hardware builds.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory loader.
// Contents:
//   BYTE_WIDTH      width of one byte-stream element
//   loader_state_t  loader FSM states
package mem_pkg;

   localparam int BYTE_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } loader_state_t;

endpackage

// File: rtl/mem_loader.sv
// Byte-stream memory loader.
// This block is the write-side counterpart of the async ROM read path.
// It packs incoming bytes little-endian into DATA_WIDTH-bit words.
// It writes those words to consecutive addresses through one synchronous write port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, abort                begin a load (IDLE only) / cancel a load
//   base_addr, word_count       first address and number of words, latched on start
//   in_valid, in_data, in_ready byte-stream handshake
//   mem_we, mem_addr, mem_wdata registered memory write port
//   busy, done                  not-idle flag, one-cycle completion pulse
module mem_loader
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
   localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   loader_state_t         state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] word_asm;

   // The current buffer with the incoming byte dropped into lane idx.
   // On the last byte this is the complete word, so it goes straight to the write registers.
   always_comb begin
      word_asm = buf_q;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (idx_q == IDX_W'(i)) word_asm[i*BYTE_WIDTH +: BYTE_WIDTH] = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = word_count;
               idx_d   = '0;
               state_d = (word_count == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (abort) begin
               idx_d   = '0;
               state_d = IDLE;
            end else if (in_valid) begin
               buf_d = word_asm;
               if (idx_q == LAST_IDX) begin
                  we_d    = 1'b1;
                  maddr_d = addr_q;
                  wdata_d = word_asm;
                  state_d = WRITE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         WRITE: begin
            // The write itself is already registered, so an abort here only skips the rest of the load.
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            idx_d  = '0;
            if (abort)                                state_d = IDLE;
            else if (rem_q == (ADDR_WIDTH+1)'(1))     state_d = DONE;
            else                                      state_d = COLLECT;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == COLLECT);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign mem_we    = we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;

endmodule
